// File: rtl/rr_arb16_pkg.sv
// Shared constants, state type and small helpers for the 16-way round-robin arbiter.
package rr_arb16_pkg;

    localparam int NUM_PORTS = 16;
    localparam int SEL_W     = 4;

    // Output register occupancy.
    typedef enum logic [0:0] {
        ST_EMPTY = 1'b0,
        ST_FULL  = 1'b1
    } state_e;

    // Pointer for the next search: one past the winner, wrapping 15 -> 0
    // through the natural 4-bit overflow.
    function automatic logic [SEL_W-1:0] next_ptr(input logic [SEL_W-1:0] winner);
        return winner + SEL_W'(1);
    endfunction

endpackage

// File: rtl/rr_arb16_mux16.sv
// 16:1 data multiplexer (the mux16 block), selected by a 4-bit index.
module rr_arb16_mux16
    import rr_arb16_pkg::*;
#(
    parameter int N = 32
) (
    input  logic [N-1:0]     i_data [NUM_PORTS],
    input  logic [SEL_W-1:0] i_sel,
    output logic [N-1:0]     o_data
);

    // Pure combinational select; the index is always in range for 16 entries.
    always_comb begin
        o_data = i_data[i_sel];
    end

endmodule

// File: rtl/rr_arb16.sv
// Round-robin arbiter: 16 valid/ready requesters into a single-entry output
// register. The grant is combinational from req_valid, the pointer and the
// output handshake only, so the data inputs never reach req_ready.
module rr_arb16
    import rr_arb16_pkg::*;
#(
    parameter int N = 32
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [NUM_PORTS-1:0] req_valid,
    input  logic [N-1:0]         in0,
    input  logic [N-1:0]         in1,
    input  logic [N-1:0]         in2,
    input  logic [N-1:0]         in3,
    input  logic [N-1:0]         in4,
    input  logic [N-1:0]         in5,
    input  logic [N-1:0]         in6,
    input  logic [N-1:0]         in7,
    input  logic [N-1:0]         in8,
    input  logic [N-1:0]         in9,
    input  logic [N-1:0]         in10,
    input  logic [N-1:0]         in11,
    input  logic [N-1:0]         in12,
    input  logic [N-1:0]         in13,
    input  logic [N-1:0]         in14,
    input  logic [N-1:0]         in15,
    output logic [NUM_PORTS-1:0] req_ready,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [N-1:0]         out_data,
    output logic [SEL_W-1:0]     out_src
);

    state_e             r_state;
    logic [N-1:0]       r_data;
    logic [SEL_W-1:0]   r_src;
    logic [SEL_W-1:0]   r_ptr;

    logic [N-1:0]       w_in [NUM_PORTS];
    logic [N-1:0]       w_mux_data;
    logic [NUM_PORTS-1:0] w_rot;
    logic [SEL_W-1:0]   w_off;
    logic [SEL_W-1:0]   w_winner;
    logic               w_any;
    logic               w_load_en;
    logic               w_grant_en;
    logic               w_out_xfer;

    assign w_in[0]  = in0;
    assign w_in[1]  = in1;
    assign w_in[2]  = in2;
    assign w_in[3]  = in3;
    assign w_in[4]  = in4;
    assign w_in[5]  = in5;
    assign w_in[6]  = in6;
    assign w_in[7]  = in7;
    assign w_in[8]  = in8;
    assign w_in[9]  = in9;
    assign w_in[10] = in10;
    assign w_in[11] = in11;
    assign w_in[12] = in12;
    assign w_in[13] = in13;
    assign w_in[14] = in14;
    assign w_in[15] = in15;

    // Rotate the request vector so bit 0 is the requester at the pointer;
    // the 4-bit index sum wraps around the ring by itself.
    genvar gi;
    generate
        for (gi = 0; gi < NUM_PORTS; gi++) begin : g_rot
            assign w_rot[gi] = req_valid[r_ptr + SEL_W'(gi)];
        end
    endgenerate

    // Lowest set bit of the rotated vector is the distance from the pointer
    // to the winner.
    always_comb begin
        w_off = '0;
        for (int i = NUM_PORTS - 1; i >= 0; i--) begin
            if (w_rot[i]) begin
                w_off = SEL_W'(i);
            end
        end
    end

    assign w_winner   = r_ptr + w_off;
    assign w_any      = |req_valid;
    assign w_load_en  = (r_state == ST_EMPTY) || out_ready;
    // Reset suppresses the grant so nothing is accepted into a register
    // that is being cleared on the same edge.
    assign w_grant_en = rst_n && w_load_en && w_any;
    assign w_out_xfer = (r_state == ST_FULL) && out_ready;

    // One-hot accept at the winner, all zero when no grant is possible.
    generate
        for (gi = 0; gi < NUM_PORTS; gi++) begin : g_ready
            assign req_ready[gi] = w_grant_en && (w_winner == SEL_W'(gi));
        end
    endgenerate

    rr_arb16_mux16 #(
        .N (N)
    ) u_mux (
        .i_data (w_in),
        .i_sel  (w_winner),
        .o_data (w_mux_data)
    );

    // Output register, occupancy state and round-robin pointer.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= ST_EMPTY;
            r_data  <= '0;
            r_src   <= '0;
            r_ptr   <= '0;
        end else if (w_grant_en) begin
            r_state <= ST_FULL;
            r_data  <= w_mux_data;
            r_src   <= w_winner;
            r_ptr   <= next_ptr(w_winner);
        end else if (w_out_xfer) begin
            r_state <= ST_EMPTY;
        end
    end

    assign out_valid = (r_state == ST_FULL);
    assign out_data  = r_data;
    assign out_src   = r_src;

endmodule

// File: tb/tb_rr_arb16.sv
// Testbench for rr_arb16: directed scenarios followed by random traffic,
// all compared against a behavioural round-robin model.
module tb_rr_arb16;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [15:0] req_valid;
    logic [31:0] in_val [16];
    logic [15:0] req_ready;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_data;
    logic [3:0]  out_src;

    int checks   = 0;
    int failures = 0;

    // Reference model state.
    bit          m_valid;
    logic [31:0] m_data;
    int          m_src;
    int          m_ptr;

    always #5 clk = ~clk;

    rr_arb16 #(.N(32)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req_valid (req_valid),
        .in0  (in_val[0]),  .in1  (in_val[1]),  .in2  (in_val[2]),  .in3  (in_val[3]),
        .in4  (in_val[4]),  .in5  (in_val[5]),  .in6  (in_val[6]),  .in7  (in_val[7]),
        .in8  (in_val[8]),  .in9  (in_val[9]),  .in10 (in_val[10]), .in11 (in_val[11]),
        .in12 (in_val[12]), .in13 (in_val[13]), .in14 (in_val[14]), .in15 (in_val[15]),
        .req_ready (req_ready),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_src   (out_src)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Winner by circular scan from the pointer; -1 when nobody requests.
    function automatic int model_winner(input logic [15:0] v, input int ptr);
        for (int k = 0; k < 16; k++) begin
            if (v[(ptr + k) % 16]) return (ptr + k) % 16;
        end
        return -1;
    endfunction

    // One clock cycle: drive inputs, check the grant, take the edge, check
    // the registered outputs. Called shortly after a rising edge.
    task automatic cycle(input string tag, input logic [15:0] v, input logic ordy, input logic rstn);
        int          w;
        bit          load_en;
        logic [15:0] exp_ready;
        req_valid = v;
        out_ready = ordy;
        rst_n     = rstn;
        #1;
        load_en   = !m_valid || ordy;
        w         = model_winner(v, m_ptr);
        exp_ready = (rstn && load_en && w >= 0) ? (16'd1 << w) : 16'd0;
        chk({tag, ".req_ready"}, 64'(req_ready), 64'(exp_ready));
        @(posedge clk);
        if (!rstn) begin
            m_valid = 0; m_data = 0; m_src = 0; m_ptr = 0;
        end else if (exp_ready != 0) begin
            m_valid = 1; m_data = in_val[w]; m_src = w; m_ptr = (w + 1) % 16;
        end else if (m_valid && ordy) begin
            m_valid = 0;
        end
        #1;
        chk({tag, ".out_valid"}, 64'(out_valid), 64'(m_valid));
        chk({tag, ".out_data"},  64'(out_data),  64'(m_data));
        chk({tag, ".out_src"},   64'(out_src),   64'(m_src));
        $display("cyc %s v=%04h ordy=%0b rst_n=%0b rdy=%04h ov=%0b src=%0d data=%08h",
                 tag, v, ordy, rstn, req_ready, out_valid, out_src, out_data);
    endtask

    initial begin
        m_valid = 0; m_data = 0; m_src = 0; m_ptr = 0;
        rst_n = 1'b0; out_ready = 1'b1; req_valid = 16'hFFFF;
        for (int i = 0; i < 16; i++) in_val[i] = $urandom;
        @(posedge clk); #1;

        // Reset with full request activity.
        cycle("reset0", 16'hFFFF, 1'b1, 1'b0);
        cycle("reset1", 16'hFFFF, 1'b1, 1'b0);

        // Full rotation 0..15 then wrap to 0.
        for (int i = 0; i < 16; i++) in_val[i] = 32'(i + 100);
        for (int i = 0; i < 17; i++) cycle("rotate", 16'hFFFF, 1'b1, 1'b1);
        cycle("drain", 16'h0000, 1'b1, 1'b1);

        // Backpressure on a single word from requester 5.
        in_val[5] = 32'hDEAD_BEEF;
        cycle("bp_load", 16'h0020, 1'b1, 1'b1);
        cycle("bp_hold0", 16'h0000, 1'b0, 1'b1);
        cycle("bp_hold1", 16'hFFFF, 1'b0, 1'b1);
        cycle("bp_hold2", 16'h0020, 1'b0, 1'b1);
        cycle("bp_hold3", 16'h0000, 1'b0, 1'b1);
        cycle("bp_release", 16'h0000, 1'b1, 1'b1);
        chk("bp_empty_after", 64'(out_valid), 64'd0);

        // Wrap fairness: grant 14, then bits 3 and 15 -> 15 then 3.
        cycle("wrap14", 16'h4000, 1'b1, 1'b1);
        cycle("wrap15", 16'h8008, 1'b1, 1'b1);
        chk("wrap_first", 64'(out_src), 64'd15);
        cycle("wrap3", 16'h8008, 1'b1, 1'b1);
        chk("wrap_second", 64'(out_src), 64'd3);

        // Back-to-back replace while full.
        in_val[7] = 32'h0707_0707;
        cycle("b2b", 16'h0080, 1'b1, 1'b1);
        chk("b2b_src", 64'(out_src), 64'd7);
        chk("b2b_valid", 64'(out_valid), 64'd1);

        // Reset while holding a word from requester 9.
        cycle("mid_load9", 16'h0200, 1'b1, 1'b1);
        cycle("mid_hold", 16'h0000, 1'b0, 1'b1);
        cycle("mid_reset", 16'hFFFF, 1'b0, 1'b0);
        cycle("mid_after", 16'hFFFF, 1'b1, 1'b1);
        chk("mid_first_grant", 64'(out_src), 64'd0);

        // Random traffic.
        for (int n = 0; n < 400; n++) begin
            logic [15:0] v;
            for (int i = 0; i < 16; i++) in_val[i] = $urandom;
            case ($urandom_range(0, 3))
                0:       v = 16'h0000;
                1:       v = 16'($urandom) & 16'($urandom) & 16'($urandom);
                2:       v = 16'd1 << $urandom_range(0, 15);
                default: v = 16'($urandom);
            endcase
            cycle("rand", v, $urandom_range(0, 3) != 0, $urandom_range(0, 50) != 0);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/rr_arb16.md
RR_ARB16 -- requirements
Module: rr_arb16

Interface
REQ-001 Parameter: N, default 32, data width of every requester and of the output.
REQ-002 Port: clk  input  1  sole clock; all state updates on its rising edge.
REQ-003 Port: rst_n  input  1  reset, synchronous, active-low.
REQ-004 Port: req_valid  input  16  per-requester valid; bit i belongs to requester i.
REQ-005 Port: in0..in15  input  N each  requester data words.
REQ-006 Port: req_ready  output  16  per-requester accept; bit i belongs to requester i.
REQ-007 Port: out_valid  output  1  output register holds a word.
REQ-008 Port: out_ready  input  1  downstream accepts the held word.
REQ-009 Port: out_data  output  N  registered winning word.
REQ-010 Port: out_src  output  4  registered index of the winning requester.

Function
REQ-011 The block SHALL arbitrate 16 requesters round-robin into a single-entry output register with valid/ready handshakes on both sides.
REQ-012 Transfer on a side SHALL occur exactly in a cycle where its valid and ready are both 1 at the clock edge.
REQ-013 load_en = !out_valid || out_ready; combinational, no registered bubble.
REQ-014 Winner = lowest index i, searched circularly from ptr (ptr, ptr+1, ..., 15, 0, ..., ptr-1), among set req_valid bits.
REQ-015 req_ready SHALL be one-hot at the winner when load_en=1 and any req_valid=1, else all zero; never more than one bit set.
REQ-016 req_ready SHALL depend only on req_valid, ptr, out_valid, out_ready (no dependency on data inputs).
REQ-017 On an input transfer: out_data <= in[winner], out_src <= winner, out_valid <= 1, ptr <= winner+1 mod 16 (15 wraps to 0).
REQ-018 On output transfer with no input transfer in the same cycle: out_valid <= 0; out_data, out_src SHALL hold their values.
REQ-019 Simultaneous output and input transfer SHALL replace the word in the same edge, sustaining one word per cycle.
REQ-020 While out_valid=1 and out_ready=0, out_data, out_src, out_valid and ptr SHALL be stable.
REQ-021 Latency: requester transfer at edge k -> word visible on out_data after edge k (one cycle).
REQ-022 No requests: ptr unchanged, no req_ready asserted.
REQ-023 A requester continuously valid SHALL wait at most 15 of its competitors' transfers before being granted.
REQ-024 States: EMPTY (out_valid=0) and FULL (out_valid=1); EMPTY->FULL on input transfer; FULL->EMPTY on output transfer without input transfer; else stay.

Reset
REQ-025 When rst_n=0 at a clock edge: out_valid=0, out_data=0, out_src=0, ptr=0, regardless of handshake activity.
REQ-026 During reset cycles req_ready SHALL be all zero; a word held mid-operation SHALL be discarded.
REQ-027 First grant after reset SHALL search starting at index 0.

Structure
REQ-028 A shared package SHALL hold NUM_PORTS=16, SEL_W=4, and the EMPTY/FULL state enum.
REQ-029 Data selection SHALL reuse the existing mux16 sub-module, driven by the 4-bit winner index; only the priority search and registers are new logic.

Verification
REQ-030 Reset: rst_n=0 with req_valid=16'hFFFF, out_ready=1 -> req_ready=0, out_valid=0, out_data=0, out_src=0.
REQ-031 Rotation: req_valid=16'hFFFF held, out_ready=1, in_i=i+100 -> out_src 0,1,...,15,0 on consecutive cycles, out_data=100+out_src, req_ready one-hot every cycle.
REQ-032 Backpressure: single word from requester 5 (data 32'hDEAD_BEEF), out_ready=0 for 4 cycles -> out_valid=1, data/src stable, req_ready=0; out_ready=1 -> out_valid=0 next cycle.
REQ-033 Fairness/wrap: after grant to 14 (ptr=15), req_valid bits 3 and 15 set -> 15 granted first, then 3.
REQ-034 Back-to-back: out_valid=1, out_ready=1, requester 7 valid -> same edge replaces word, out_src=7, no idle cycle.
REQ-035 Reset mid-operation: FULL with out_src=9, ptr=10, rst_n=0 one cycle -> out_valid=0, next grant searches from index 0.
